flit_demux1to4: RTL and testbench
=================================

// Module: flit_demux1to4
// PURPOSE
//  Registered 1-to-4 flit demultiplexer, the steering counterpart of the 4:1 flit mux.
//  Takes one flit stream plus a 2-bit destination select and writes each flit into one of four per-output FIFOs.
//  Used on router ejection and redirection paths, where one source feeds four sinks under valid/ready flow control.
//  Each sink can stall on its own without blocking flits bound for the other sinks, unless the selected FIFO is full.
// PARAMETERS
//  DATA_W   64  flit width in bits
//  DEPTH    2   entries per output FIFO; power of 2, >=2
//  PTR_W    $clog2(DEPTH)  pointer width (derived, not overridden)
// PORTS
//  clk          in   1         single clock; all state updates on posedge clk
//  reset_n      in   1         synchronous active-low reset, sampled on posedge clk
//  din          in   DATA_W    input flit
//  din_valid    in   1         din/sel valid this cycle
//  sel          in   2         destination output 0..3; stable while din_valid=1
//  din_ready    out  1         selected FIFO can accept; transfer when din_valid&din_ready
//  dout_k       out  DATA_W    head flit of FIFO k (k=0..3), four ports
//  dout_valid   out  4         bit k: FIFO k non-empty
//  dout_ready   in   4         bit k: sink k consumes head this cycle
//  occ          out  4*(PTR_W+1)  per-FIFO occupancy, field k at [k*(PTR_W+1) +: PTR_W+1]
// BEHAVIOUR
//  - Interface: one clock (clk); reset_n is synchronous and active-low.
//  - Reset (reset_n=0 at posedge): all wr/rd pointers=0, occ=0, storage=0.
//      dout_valid=4'b0, every dout_k=0; din_ready=1 from the following cycle.
//  - Reset mid-operation flushes every FIFO. In-flight flits are dropped and no handshake completes in the reset cycle.
//  - din_ready = ~full[sel], combinational from sel and registered occupancy only.
//      No full-bypass: a pop on FIFO k in the same cycle does not raise din_ready for sel=k.
//      din_ready may be high while din_valid=0. The source must not change sel while din_valid=1 and din_ready=0.
//  - Push: din_valid&din_ready writes din at wr_ptr[sel], wr_ptr[sel]++ (wraps mod DEPTH), occ[sel]++.
//  - Latency: a flit pushed in cycle N appears on dout_k with dout_valid[k]=1 in cycle N+1. There is no same-cycle pass-through.
//  - Pop: dout_valid[k]&dout_ready[k] advances rd_ptr[k] (wraps mod DEPTH), occ[k]--.
//      dout_ready[k] while empty is ignored.
//  - Simultaneous push and pop on the same k: occ[k] unchanged, both pointers advance, order preserved.
//      When empty, the pushed flit shows next cycle.
//  - Pops on different outputs are fully independent; up to 4 pops plus 1 push per cycle.
//  - dout_k always drives storage[rd_ptr[k]]; its value is don't-care when dout_valid[k]=0.
//  - Per-output order is FIFO. No ordering is guaranteed across outputs.
//  - occ[k] ranges 0..DEPTH. full[k] = (occ[k]==DEPTH), empty[k] = (occ[k]==0).
//  - Flits are never lost or duplicated outside reset.
//  - Assertions (sim only):
//      occ[k] never exceeds DEPTH and never underflows.
//      sel holds stable while din_valid=1 and din_ready=0.
// TESTING
//  1 Reset: hold reset_n=0 3 cycles with din_valid=1
//      -> dout_valid=0, occ=0, no writes; first cycle after release din_ready=1.
//  2 Steering: push 0xA0,0xA1,0xA2,0xA3 with sel=0,1,2,3, dout_ready=4'hF
//      -> each dout_k=0xAk one cycle after its push, then dout_valid drops.
//  3 Full/backpressure: DEPTH=2, dout_ready[2]=0, push 0x10,0x11,0x12 to sel=2
//      -> occ[2]=2, din_ready=0 on the 3rd push.
//      Raise dout_ready[2] -> 0x10 pops, din_ready goes high one cycle later, 0x12 accepted, order 0x11,0x12.
//  4 Head-of-line isolation: FIFO 1 full and stalled, push 0x55 to sel=3
//      -> accepted immediately, appears on dout_3 next cycle.
//  5 Simultaneous push/pop: occ[0]=1, push 0x77 to sel=0 while popping
//      -> occ[0] stays 1; after 2*DEPTH+1 such cycles the pointers have wrapped and data order is still correct.
//  6 Reset mid-stream: all FIFOs partially full, pulse reset_n=0 for 1 cycle
//      -> all occ=0, dout_valid=0; next pushed flit is the first one seen on its output.

Source files
------------

// File: rtl/flit_demux1to4.sv
// Registered 1-to-4 flit demultiplexer: one valid/ready input stream steered by sel
// into four independent output FIFOs, each with its own valid/ready sink interface.
module flit_demux1to4 #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [DATA_W-1:0]        din,
  input  logic                     din_valid,
  input  logic [1:0]               sel,
  output logic                     din_ready,
  output logic [DATA_W-1:0]        dout_0,
  output logic [DATA_W-1:0]        dout_1,
  output logic [DATA_W-1:0]        dout_2,
  output logic [DATA_W-1:0]        dout_3,
  output logic [3:0]               dout_valid,
  input  logic [3:0]               dout_ready,
  output logic [4*(PTR_W+1)-1:0]   occ
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [3:0]             full;
  logic [3:0]             push;
  logic [3:0]             pop;
  logic [3:0][DATA_W-1:0] head;

  // Readiness looks only at registered occupancy, so a same-cycle pop never unblocks a full FIFO.
  assign din_ready = ~full[sel];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_fifo
      logic [DATA_W-1:0] mem_q [DEPTH];
      logic [DATA_W-1:0] mem_d [DEPTH];
      logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
      logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
      logic [PTR_W:0]    occ_q, occ_d;

      assign push[gi] = din_valid & din_ready & (sel == 2'(gi));
      assign pop[gi]  = (occ_q != '0) & dout_ready[gi];
      assign full[gi] = (occ_q == DEPTH_C);

      always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push[gi]) begin
          mem_d[wr_ptr_q] = din;
          wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop[gi]) begin
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push[gi], pop[gi]})
          2'b10:   occ_d = occ_q + (PTR_W+1)'(1);
          2'b01:   occ_d = occ_q - (PTR_W+1)'(1);
          default: occ_d = occ_q;
        endcase
      end

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
          end
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          occ_q    <= '0;
        end else begin
          mem_q    <= mem_d;
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
          occ_q    <= occ_d;
        end
      end

      assign head[gi]                          = mem_q[rd_ptr_q];
      assign dout_valid[gi]                    = (occ_q != '0);
      assign occ[gi*(PTR_W+1) +: (PTR_W+1)]    = occ_q;

`ifndef SYNTHESIS
      a_occ_range: assert property (@(posedge clk) disable iff (!reset_n) occ_q <= DEPTH_C);
      a_no_underflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(pop[gi] && (occ_q == '0)));
`endif
    end
  endgenerate

  assign dout_0 = head[0];
  assign dout_1 = head[1];
  assign dout_2 = head[2];
  assign dout_3 = head[3];

`ifndef SYNTHESIS
  a_sel_stable: assert property (@(posedge clk) disable iff (!reset_n)
    (din_valid && !din_ready) |=> (!din_valid || sel == $past(sel)));
`endif

endmodule

// File: tb/tb_flit_demux1to4.sv
// Scoreboard bench for flit_demux1to4: per-output expected queues filled on accepted
// pushes, drained by an independent monitor that checks every output each cycle.
module tb_flit_demux1to4;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 2;
  localparam int OW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [DATA_W-1:0] din = '0;
  logic              din_valid = 1'b0;
  logic [1:0]        sel = 2'd0;
  logic              din_ready;
  logic [DATA_W-1:0] dout_0, dout_1, dout_2, dout_3;
  logic [3:0]        dout_valid;
  logic [3:0]        dout_ready = 4'h0;
  logic [4*OW-1:0]   occ;

  always #5 clk = ~clk;

  flit_demux1to4 #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .din(din), .din_valid(din_valid), .sel(sel),
    .din_ready(din_ready), .dout_0(dout_0), .dout_1(dout_1), .dout_2(dout_2),
    .dout_3(dout_3), .dout_valid(dout_valid), .dout_ready(dout_ready), .occ(occ)
  );

  logic [DATA_W-1:0] exp_q [4][$];
  int checks = 0;
  int failures = 0;
  bit stall = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [DATA_W-1:0] dout_of(input int k);
    case (k)
      0:       return dout_0;
      1:       return dout_1;
      2:       return dout_2;
      default: return dout_3;
    endcase
  endfunction

  // Monitor: compares the visible state of this cycle against the model, then retires pops.
  always @(negedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < 4; k++) exp_q[k].delete();
    end else begin
      chk("din_ready", 64'(din_ready), 64'(exp_q[sel].size() != DEPTH));
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("dout_valid[%0d]", k), 64'(dout_valid[k]), 64'(exp_q[k].size() != 0));
        chk($sformatf("occ[%0d]", k), 64'(occ[k*OW +: OW]), 64'(exp_q[k].size()));
        if (exp_q[k].size() != 0) begin
          chk($sformatf("dout_%0d", k), dout_of(k), exp_q[k][0]);
          if (dout_ready[k]) void'(exp_q[k].pop_front());
        end
      end
    end
  end

  // One clock of stimulus; an accepted flit is pushed into the expected queue of its output.
  task automatic step(input logic rst_n, input logic v, input logic [1:0] s,
                      input logic [DATA_W-1:0] d, input logic [3:0] rdy, output logic acc);
    @(posedge clk);
    #1;
    reset_n = rst_n; din_valid = v; sel = s; din = d; dout_ready = rdy;
    @(negedge clk);
    #1;
    acc = rst_n && v && din_ready;
    if (acc) exp_q[s].push_back(d);
    stall = rst_n && v && !din_ready;
  endtask

  logic acc;
  logic [1:0] rsel;
  logic [DATA_W-1:0] rdat;

  initial begin
    // Reset held with valid asserted
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'(i), 64'hDEAD, 4'hF, acc);
    step(1'b1, 1'b0, 2'd0, 64'h0, 4'h0, acc);
    chk("reset_din_ready", 64'(din_ready), 64'd1);
    chk("reset_dout_valid", 64'(dout_valid), 64'd0);
    chk("reset_occ", 64'(occ), 64'd0);
    for (int k = 0; k < 4; k++) chk($sformatf("reset_dout_%0d", k), dout_of(k), 64'd0);

    // Steering
    for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 2'(k), 64'hA0 + 64'(k), 4'hF, acc);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 2'd0, 64'h0, 4'hF, acc);

    // Full / backpressure on output 2
    step(1'b1, 1'b1, 2'd2, 64'h10, 4'b1011, acc);
    step(1'b1, 1'b1, 2'd2, 64'h11, 4'b1011, acc);
    step(1'b1, 1'b1, 2'd2, 64'h12, 4'b1011, acc);
    chk("full_third_push_acc", 64'(acc), 64'd0);
    chk("full_occ2", 64'(occ[2*OW +: OW]), 64'(DEPTH));
    step(1'b1, 1'b1, 2'd2, 64'h12, 4'hF, acc);
    chk("no_bypass_acc", 64'(acc), 64'd0);
    step(1'b1, 1'b1, 2'd2, 64'h12, 4'hF, acc);
    chk("after_pop_acc", 64'(acc), 64'd1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'd0, 64'h0, 4'hF, acc);

    // Head-of-line isolation
    step(1'b1, 1'b1, 2'd1, 64'h40, 4'b0101, acc);
    step(1'b1, 1'b1, 2'd1, 64'h41, 4'b0101, acc);
    step(1'b1, 1'b1, 2'd3, 64'h55, 4'b0101, acc);
    chk("hol_acc", 64'(acc), 64'd1);
    step(1'b1, 1'b0, 2'd0, 64'h0, 4'b0101, acc);
    chk("hol_dout_3", dout_3, 64'h55);
    chk("hol_valid", 64'(dout_valid), 64'b1010);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'd0, 64'h0, 4'hF, acc);

    // Simultaneous push/pop across pointer wrap
    step(1'b1, 1'b1, 2'd0, 64'h70, 4'h0, acc);
    for (int i = 0; i < 2*DEPTH+1; i++) begin
      step(1'b1, 1'b1, 2'd0, 64'h77 + 64'(i), 4'h1, acc);
      chk("pushpop_acc", 64'(acc), 64'd1);
      chk("pushpop_occ0", 64'(occ[0 +: OW]), 64'd1);
    end
    step(1'b1, 1'b0, 2'd0, 64'h0, 4'h0, acc);
    chk("pushpop_final_occ0", 64'(occ[0 +: OW]), 64'd1);
    chk("pushpop_final_head", dout_0, 64'h77 + 64'(2*DEPTH));
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 2'd0, 64'h0, 4'hF, acc);

    // Reset mid-stream
    for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 2'(k), 64'h60 + 64'(k), 4'h0, acc);
    step(1'b0, 1'b1, 2'd1, 64'hEE, 4'h0, acc);
    step(1'b1, 1'b0, 2'd0, 64'h0, 4'h0, acc);
    chk("midreset_occ", 64'(occ), 64'd0);
    chk("midreset_valid", 64'(dout_valid), 64'd0);
    step(1'b1, 1'b1, 2'd2, 64'h99, 4'h0, acc);
    step(1'b1, 1'b0, 2'd0, 64'h0, 4'h0, acc);
    chk("midreset_first_flit", dout_2, 64'h99);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 2'd0, 64'h0, 4'hF, acc);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      if (stall) begin
        step(1'b1, 1'b1, sel, din, 4'($urandom_range(0, 15)), acc);
      end else if ($urandom_range(0, 149) == 0) begin
        step(1'b0, 1'b1, 2'($urandom_range(0, 3)), 64'h0, 4'hF, acc);
      end else begin
        rsel = 2'($urandom_range(0, 3));
        rdat = {$urandom(), $urandom()};
        step(1'b1, ($urandom_range(0, 3) != 0), rsel, rdat, 4'($urandom_range(0, 15)), acc);
      end
    end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 2'd0, 64'h0, 4'hF, acc);
    chk("drain_valid", 64'(dout_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
